// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes: streams NumBytes bytes through one shared S-box, one byte per cycle.
// Optional `AES_SUB_BYTES_PIPE_EN adds a register stage between the S-box output and the state write port.
module aes_sub_bytes_seq #(
    parameter int NumBytes = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            op_i,
    input  logic [8*NumBytes-1:0] data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [8*NumBytes-1:0] data_o,
    output logic                  busy_o
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready_o=1
    // RUN   | one byte per cycle through the S-box
    // DONE  | result held on data_o until out_ready_i
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int            CW   = $clog2(NumBytes) + 1;
    localparam logic [CW-1:0] LAST = CW'(NumBytes - 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(r, r);
            r = gf_mul(r, x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    fsm_t                  fsm_q, fsm_d;
    logic [8*NumBytes-1:0] st_q;
    logic [1:0]            op_q;
    logic [CW-1:0]         cnt_q;
    logic [7:0]            sel_byte, sbox_out;
    logic                  accept, issue, cnt_inc, last_wr, wr_en;
    logic [CW-1:0]         wr_idx;
    logic [7:0]            wr_data;

    assign accept = (fsm_q == IDLE) && in_valid_i && !clear_i;
    assign issue  = (fsm_q == RUN) && (cnt_q < CW'(NumBytes));

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NumBytes; i++) begin
            if (cnt_q == CW'(i)) sel_byte = st_q[8*i +: 8];
        end
    end

    // Reserved op codes fall through to forward.
    assign sbox_out = (op_q == 2'b10) ? sbox_inv(sel_byte) : sbox_fwd(sel_byte);

`ifdef AES_SUB_BYTES_PIPE_EN
    logic          pipe_vld_q;
    logic [7:0]    pipe_data_q;
    logic [CW-1:0] pipe_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= 8'h00;
            pipe_idx_q  <= '0;
        end else if (clear_i) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= 8'h00;
            pipe_idx_q  <= '0;
        end else begin
            pipe_vld_q <= issue;
            if (issue) begin
                pipe_data_q <= sbox_out;
                pipe_idx_q  <= cnt_q;
            end
        end
    end

    assign cnt_inc = issue;
    assign wr_en   = pipe_vld_q;
    assign wr_idx  = pipe_idx_q;
    assign wr_data = pipe_data_q;
    assign last_wr = pipe_vld_q && (pipe_idx_q == LAST);
`else
    assign cnt_inc = issue && (cnt_q != LAST);
    assign wr_en   = issue;
    assign wr_idx  = cnt_q;
    assign wr_data = sbox_out;
    assign last_wr = issue && (cnt_q == LAST);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fsm_q <= IDLE;
        else         fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid_i)  fsm_d = RUN;
            RUN:     if (last_wr)     fsm_d = DONE;
            DONE:    if (out_ready_i) fsm_d = IDLE;
            default:                  fsm_d = IDLE;
        endcase
        if (clear_i) fsm_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q  <= '0;
            op_q  <= 2'b00;
            cnt_q <= '0;
        end else if (clear_i) begin
            st_q  <= '0;
            op_q  <= 2'b00;
            cnt_q <= '0;
        end else if (accept) begin
            st_q  <= data_i;
            op_q  <= op_i;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < NumBytes; i++) begin
                    if (wr_idx == CW'(i)) st_q[8*i +: 8] <= wr_data;
                end
            end
            if (cnt_inc) cnt_q <= cnt_q + CW'(1);
            // Scrub the result as it leaves.
            if ((fsm_q == DONE) && out_ready_i) begin
                st_q  <= '0;
                cnt_q <= '0;
            end
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q != IDLE);
    assign data_o      = out_valid_o ? st_q : '0;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Scoreboard bench for aes_sub_bytes_seq: 16-byte and 4-byte instances against a table-built S-box model.
module tb_aes_sub_bytes_seq;
    localparam int N = 16;
`ifdef AES_SUB_BYTES_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, clear, in_valid, out_ready;
    logic [1:0]   op;
    logic [127:0] din;
    logic         in_ready, out_valid, busy;
    logic [127:0] dout;

    logic         in_valid4, out_ready4;
    logic [1:0]   op4;
    logic [31:0]  din4;
    logic         in_ready4, out_valid4, busy4;
    logic [31:0]  dout4;

    aes_sub_bytes_seq #(.NumBytes(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op), .data_i(din),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout), .busy_o(busy)
    );

    aes_sub_bytes_seq #(.NumBytes(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .op_i(op4), .data_i(din4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4), .data_o(dout4), .busy_o(busy4)
    );

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] sb_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] iv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
            fwd_tab[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [1:0] o, input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = (o == 2'b10) ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send16(input logic [1:0] o, input logic [127:0] d, input logic [127:0] expv);
        @(negedge clk);
        in_valid = 1'b1; op = o; din = d;
        sb_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0; op = ~o; din = ~d;
        chk("busy_after_accept", {127'b0, busy}, 128'd1);
    endtask

    task automatic run16(input logic [1:0] o, input logic [127:0] d, input logic [127:0] expv, input int hold);
        int cyc;
        logic [127:0] e;
        out_ready = (hold == 0);
        send16(o, d, expv);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 128'(cyc), 128'(N + EXTRA));
        e = sb_q.pop_front();
        chk("data", dout, e);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; din = rnd128(); op = 2'b10;
            @(negedge clk);
            chk("hold_valid", {127'b0, out_valid}, 128'd1);
            chk("hold_data", dout, e);
            chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", {127'b0, out_valid}, 128'd0);
        chk("post_data", dout, 128'd0);
        chk("post_in_ready", {127'b0, in_ready}, 128'd1);
        chk("post_busy", {127'b0, busy}, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v0, vf, vi, r;
        logic [1:0]   ro;
        int           cyc;
        bit           seen;
        build_tables();
        v0 = 128'h0f0e0d0c0b0a09080706050403020100;
        vf = 128'h76abd7fe2b670130c56f6bf27b777c63;
        vi = 128'hfbd7f3819ea340bf38a53630d56a0952;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; din = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; op4 = 2'b00; din4 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_data", dout, 128'd0);

        run16(2'b01, v0, vf, 0);
        run16(2'b10, v0, vi, 0);
        run16(2'b01, vi, v0, 0);
        run16(2'b11, {16{8'h53}}, {16{8'hed}}, 0);
        run16(2'b00, {16{8'h00}}, {16{8'h63}}, 0);
        run16(2'b01, v0, vf, 10);
        for (int k = 0; k < 4; k++) begin
            r  = rnd128();
            ro = 2'($urandom_range(0, 3));
            run16(ro, r, model(ro, r), k % 2);
        end

        // Abort at byte 7; a same-cycle request must be dropped.
        out_ready = 1'b1;
        send16(2'b01, v0, vf);
        void'(sb_q.pop_front());
        repeat (7) @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; din = v0; op = 2'b01;
        @(negedge clk);
        chk("clr_busy", {127'b0, busy}, 128'd0);
        chk("clr_in_ready", {127'b0, in_ready}, 128'd1);
        chk("clr_valid", {127'b0, out_valid}, 128'd0);
        clear = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("clr_no_result", {127'b0, seen}, 128'd0);
        run16(2'b10, v0, vi, 0);

        send16(2'b01, v0, vf);
        void'(sb_q.pop_front());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("arst_busy", {127'b0, busy}, 128'd0);
        chk("arst_valid", {127'b0, out_valid}, 128'd0);
        chk("arst_data", dout, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run16(2'b01, v0, vf, 0);

        // Key-schedule width instance.
        @(negedge clk);
        in_valid4 = 1'b1; op4 = 2'b01; din4 = 32'h01000000;
        @(negedge clk);
        in_valid4 = 1'b0; din4 = 32'hffffffff;
        cyc = 0;
        while (!out_valid4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("n4_latency", 128'(cyc), 128'(4 + EXTRA));
        chk("n4_data", {96'b0, dout4}, {96'b0, 32'h7c636363});
        @(negedge clk);
        chk("n4_post_valid", {127'b0, out_valid4}, 128'd0);
        chk("n4_post_data", {96'b0, dout4}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
